// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end: frame states,
// scancode-set-2 prefixes, and the scancode to HID keycode map.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_Z     = 8'h1A;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] HID_NONE  = 8'd0;
    localparam logic [7:0] HID_W     = 8'd26;
    localparam logic [7:0] HID_A     = 8'd4;
    localparam logic [7:0] HID_S     = 8'd22;
    localparam logic [7:0] HID_D     = 8'd7;
    localparam logic [7:0] HID_Z     = 8'd29;
    localparam logic [7:0] HID_ENTER = 8'd40;
    localparam logic [7:0] HID_SPACE = 8'd44;

    // Arrow keys alias onto W/A/S/D so movement logic only watches one set.
    function automatic logic [7:0] ps2_to_hid(input logic [7:0] sc, input logic ext);
        logic [7:0] hid;
        hid = HID_NONE;
        if (ext) begin
            case (sc)
                SC_UP:    hid = HID_W;
                SC_LEFT:  hid = HID_A;
                SC_DOWN:  hid = HID_S;
                SC_RIGHT: hid = HID_D;
                default:  hid = HID_NONE;
            endcase
        end else begin
            case (sc)
                SC_W:     hid = HID_W;
                SC_A:     hid = HID_A;
                SC_S:     hid = HID_S;
                SC_D:     hid = HID_D;
                SC_Z:     hid = HID_Z;
                SC_ENTER: hid = HID_ENTER;
                SC_SPACE: hid = HID_SPACE;
                default:  hid = HID_NONE;
            endcase
        end
        return hid;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: pin synchronizers, clock glitch filter,
// 11-bit frame FSM with odd-parity and stop-bit checking, and a partial-frame timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int CLK_FILTER_LEN = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic         byte_valid,
    output logic [7:0]   byte_data,
    output logic         frame_err,
    output frame_state_t state
);

    localparam int FW = $clog2(CLK_FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt;
    logic          parity_q;
    logic          accept;
    logic          reject;
    frame_state_t  state_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // The filtered level follows the pin only after CLK_FILTER_LEN agreeing samples.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(CLK_FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign fall    = clk_filt && !clk_sync[1] && (filt_cnt == FW'(CLK_FILTER_LEN - 1));
    assign timeout = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES)) && !fall;

    always_ff @(posedge Clk) begin
        if (Reset || fall || state == ST_IDLE) begin
            to_cnt <= '0;
        end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        if (timeout) begin
            state_next = ST_IDLE;
            reject     = 1'b1;
        end else if (fall) begin
            unique case (state)
                ST_IDLE:   if (!data_sync[1]) state_next = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_next = ST_PARITY;
                ST_PARITY: state_next = ST_STOP;
                ST_STOP: begin
                    state_next = ST_IDLE;
                    if (data_sync[1] && (^{shift_q, parity_q})) accept = 1'b1;
                    else                                          reject = 1'b1;
                end
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt    <= '0;
            parity_q   <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            byte_valid <= accept;
            frame_err  <= reject;
            if (accept) byte_data <= shift_q;
            if (fall) begin
                case (state)
                    ST_IDLE:   bit_cnt <= '0;
                    ST_DATA: begin
                        shift_q <= {data_sync[1], shift_q[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    ST_PARITY: parity_q <= data_sync[1];
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_source.sv
// Turns received scancode bytes into a held HID keycode: tracks E0/F0 prefixes,
// maps the code, and applies the last-press-wins hold rule.
module ps2_keycode_source
    import ps2_pkg::*;
#(
    parameter int CLK_FILTER_LEN = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic       frame_err
);

    logic         byte_valid;
    logic [7:0]   byte_data;
    frame_state_t rx_state_unused;
    logic         ext_q;
    logic         brk_q;
    logic [7:0]   hid;

    ps2_rx_frame #(
        .CLK_FILTER_LEN (CLK_FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .Clk        (Clk),
        .Reset      (Reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .state      (rx_state_unused)
    );

    assign hid = ps2_to_hid(byte_data, ext_q);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            keycode   <= '0;
            key_event <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (frame_err) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byte_valid) begin
                if (byte_data == SC_EXT) begin
                    ext_q <= 1'b1;
                end else if (byte_data == SC_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    // Releasing a key other than the held one leaves the held code alone.
                    if (hid != HID_NONE) begin
                        if (brk_q) begin
                            if (hid == keycode) begin
                                keycode   <= HID_NONE;
                                key_event <= 1'b1;
                            end
                        end else if (hid != keycode) begin
                            keycode   <= hid;
                            key_event <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_source.sv
// Directed bench for ps2_keycode_source: a table of scancode frames with
// expected keycode / event / error counts, plus timeout and mid-frame reset sequences.
module tb_ps2_keycode_source;

    localparam int FILT = 4;
    localparam int TMO  = 300;
    localparam int HALF = 20;

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic [7:0] exp_kc;
        int         exp_ev;
        int         exp_err;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       key_event;
    logic       frame_err;

    int         checks = 0;
    int         errors = 0;
    int         ev_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] prev_kc = 8'd0;
    logic       prev_rst = 1'b1;
    vec_t       vecs[$];

    ps2_keycode_source #(
        .CLK_FILTER_LEN (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode   (keycode),
        .key_event (key_event),
        .frame_err (frame_err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // key_event must coincide exactly with the first cycle of a new keycode value.
    always @(negedge Clk) begin
        if (key_event) ev_cnt++;
        if (frame_err) err_cnt++;
        if (!Reset && !prev_rst && ((keycode !== prev_kc) || key_event)) begin
            checks++;
            if ((keycode !== prev_kc) !== key_event) begin
                errors++;
                $display("FAIL key_event_align: key_event=%0b keycode %0d->%0d", key_event, prev_kc, keycode);
            end
        end
        prev_kc  = keycode;
        prev_rst = Reset;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] code, input logic bad_par, input int nbits);
        logic [10:0] frame;
        logic        par;
        par   = bad_par ? (^code) : ~(^code);
        frame = {1'b1, par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic clear_counts();
        ev_cnt  = 0;
        err_cnt = 0;
    endtask

    initial begin
        Reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(5);
        check_val("reset_keycode", int'(keycode), 0);
        check_val("reset_key_event", int'(key_event), 0);
        check_val("reset_frame_err", int'(frame_err), 0);
        Reset = 1'b0;
        tick(20);

        vecs.push_back('{8'h1D, 1'b0, 8'd26, 1, 0});
        vecs.push_back('{8'hF0, 1'b0, 8'd26, 0, 0});
        vecs.push_back('{8'h1D, 1'b0, 8'd0,  1, 0});
        vecs.push_back('{8'hE0, 1'b0, 8'd0,  0, 0});
        vecs.push_back('{8'h6B, 1'b0, 8'd4,  1, 0});
        vecs.push_back('{8'hE0, 1'b0, 8'd4,  0, 0});
        vecs.push_back('{8'hF0, 1'b0, 8'd4,  0, 0});
        vecs.push_back('{8'h6B, 1'b0, 8'd0,  1, 0});
        vecs.push_back('{8'hE0, 1'b0, 8'd0,  0, 0});
        vecs.push_back('{8'h7D, 1'b0, 8'd0,  0, 0});
        vecs.push_back('{8'h1D, 1'b0, 8'd26, 1, 0});
        vecs.push_back('{8'h23, 1'b0, 8'd7,  1, 0});
        vecs.push_back('{8'hF0, 1'b0, 8'd7,  0, 0});
        vecs.push_back('{8'h1D, 1'b0, 8'd7,  0, 0});
        vecs.push_back('{8'h23, 1'b0, 8'd7,  0, 0});
        vecs.push_back('{8'h1C, 1'b1, 8'd7,  0, 1});
        vecs.push_back('{8'h1C, 1'b0, 8'd4,  1, 0});
        vecs.push_back('{8'h5A, 1'b0, 8'd40, 1, 0});
        vecs.push_back('{8'h29, 1'b0, 8'd44, 1, 0});
        vecs.push_back('{8'h1A, 1'b0, 8'd29, 1, 0});
        vecs.push_back('{8'hE0, 1'b0, 8'd29, 0, 0});
        vecs.push_back('{8'h75, 1'b0, 8'd26, 1, 0});
        vecs.push_back('{8'hE0, 1'b0, 8'd26, 0, 0});
        vecs.push_back('{8'h72, 1'b0, 8'd22, 1, 0});
        vecs.push_back('{8'hE0, 1'b0, 8'd22, 0, 0});
        vecs.push_back('{8'h74, 1'b0, 8'd7,  1, 0});
        vecs.push_back('{8'hF0, 1'b0, 8'd7,  0, 0});
        vecs.push_back('{8'h74, 1'b0, 8'd7,  0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            clear_counts();
            send_bits(vecs[i].code, vecs[i].bad_par, 11);
            tick(20);
            check_val($sformatf("vec%0d_keycode", i), int'(keycode), int'(vecs[i].exp_kc));
            check_val($sformatf("vec%0d_events", i), ev_cnt, vecs[i].exp_ev);
            check_val($sformatf("vec%0d_frame_err", i), err_cnt, vecs[i].exp_err);
        end

        // Break prefix followed by a timed-out partial frame: the timeout must drop the prefix.
        send_bits(8'hF0, 1'b0, 11);
        tick(20);
        clear_counts();
        send_bits(8'h1B, 1'b0, 6);
        tick(TMO + 50);
        check_val("timeout_frame_err", err_cnt, 1);
        check_val("timeout_keycode", int'(keycode), 7);
        check_val("timeout_events", ev_cnt, 0);
        clear_counts();
        send_bits(8'h1B, 1'b0, 11);
        tick(20);
        check_val("after_timeout_keycode", int'(keycode), 22);
        check_val("after_timeout_events", ev_cnt, 1);
        check_val("after_timeout_frame_err", err_cnt, 0);

        // Reset in the middle of a frame abandons it without an error pulse.
        clear_counts();
        send_bits(8'h1C, 1'b0, 4);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        check_val("midreset_keycode", int'(keycode), 0);
        check_val("midreset_key_event", int'(key_event), 0);
        tick(TMO + 50);
        check_val("midreset_frame_err", err_cnt, 0);
        clear_counts();
        send_bits(8'h1C, 1'b0, 11);
        tick(20);
        check_val("after_reset_keycode", int'(keycode), 4);
        check_val("after_reset_events", ev_cnt, 1);
        check_val("after_reset_frame_err", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_source.md
# ps2_keycode_source

Receives raw PS/2 keyboard frames (scancode set 2) and presents a held 8-bit USB-HID-style keycode to game logic. It is the producer for the `keycode` input consumed by the heart movement and menu blocks. Make/break and extended prefixes are tracked so `keycode` stays nonzero only while the most recently pressed mapped key is held. It sits between the board PS/2 pins and all keycode consumers, and replaces the host-side keycode path.

## Interface
- `CLK_FILTER_LEN`, default 4: consecutive equal samples required before the filtered `ps2_clk` level changes.
- `TIMEOUT_CYCLES`, default 100000: `Clk` cycles without a PS/2 falling edge before a partial frame is aborted (2 ms at 50 MHz).
- `Clk`  in  1  system clock, single clock domain.
- `Reset`  in  1  synchronous, active-high.
- `ps2_clk`  in  1  asynchronous PS/2 clock pin.
- `ps2_data`  in  1  asynchronous PS/2 data pin.
- `keycode`  out  8  held HID code, or 0 when no mapped key is held.
- `key_event`  out  1  one-cycle pulse whenever `keycode` changes value.
- `frame_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- Input conditioning: both pins pass through a 2-FF synchronizer. `ps2_clk` is then filtered per `CLK_FILTER_LEN`. A falling edge is the filtered level changing 1→0; `ps2_data` is sampled (synchronized) in that cycle.
- Frame FSM, one transition per falling edge:
  - IDLE: data 0 → DATA (bit count 0); data 1 → stay in IDLE silently (glitch).
  - DATA: shift bits LSB first; after the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: accept if data=1 and (ones in byte + parity bit) is odd; else pulse `frame_err`. Both cases → IDLE.
- Timeout: the counter resets on every falling edge and runs only outside IDLE. When it reaches `TIMEOUT_CYCLES`, pulse `frame_err`, go to IDLE and clear the prefix flags.
- Decode runs on each accepted byte, with flags `ext` and `brk`:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other byte is looked up with the current `ext`, then both flags clear.
  - Any `frame_err` also clears both flags.
- Map, plain codes: 1D→26 (W), 1C→4 (A), 1B→22 (S), 23→7 (D), 1A→29 (Z), 5A→40 (Enter), 29→44 (Space).
- Map, with `ext` set: 75→26, 6B→4, 72→22, 74→7. Arrow keys alias onto the W/A/S/D codes.
- Unmapped codes are ignored.
- Hold rule:
  - Make of a mapped key sets `keycode` to its HID value (last press wins).
  - Break whose mapped value equals the current `keycode` clears it to 0.
  - Break of any other key: no change.
  - Typematic repeat of the same make: no change and no `key_event`.

## Timing
- Reset values: `keycode`=0, `key_event`=0, `frame_err`=0, FSM in IDLE, flags and counters cleared. Reset mid-frame abandons the frame with no error pulse.
- Pin-to-edge latency is 2 sync cycles plus `CLK_FILTER_LEN` filter cycles.
- Let cycle S be the cycle in which the stop-bit edge is detected. The accepted byte is registered in S+1; `keycode` and `key_event` update in S+2. `frame_err` asserts in S+1.
- `key_event` is high exactly in the first cycle that the new `keycode` value is visible.
- Simultaneous timeout and falling edge: the edge wins and the counter resets.
- 8-bit parity is computed as an XOR reduction. The bit counter is 3 bits and the timeout counter is $clog2(`TIMEOUT_CYCLES`+1) bits, saturating.

## Structure
- Package `ps2_pkg` holds:
  - frame FSM state enum;
  - prefix constants (E0, F0);
  - scancode and HID code constants;
  - a `function` implementing the scancode→HID map (returns 0 for unmapped).
- Sub-module `ps2_rx_frame` covers synchronizer, filter, frame FSM, parity and timeout. It outputs `byte_valid`, `byte_data` and `frame_err`.
- Top level covers prefix flags, lookup and hold rule.

## Test plan
- Frame 0x1D with odd parity bit 1 → `keycode`=26 in S+2, one `key_event` pulse, no `frame_err`.
- Then F0, 1D → `keycode`=0 with one `key_event` pulse; the F0 byte alone produces no output change.
- E0, 6B → `keycode`=4; then E0, F0, 6B → `keycode`=0. E0, 7D (unmapped) → no change.
- 1D, then 23, then F0 1D → `keycode` goes 26, 7, stays 7. Repeated 23 → no `key_event`.
- 0x1C with wrong parity → `frame_err` one pulse and `keycode` unchanged. A following valid 0x1C → `keycode`=4.
- Stop after 5 data bits and idle `TIMEOUT_CYCLES` → `frame_err` pulse, then a full 0x1B frame → `keycode`=22. Assert `Reset` mid-frame → `keycode`=0 the next cycle and no `frame_err`.
